// File: rtl/trisc_pcu_if.sv
// Decoder/ROM-side bus of the T-RISC program-control unit.
// The master drives opcode, target and flags; the slave (trisc_pcu) returns PC and stack status.
interface trisc_pcu_if #(
    parameter int AW = 12,
    parameter int DW = 6
);
    logic [5:0]    op6;
    logic [AW-1:0] imm;
    logic          z;
    logic          c;
    logic          irq;
    logic [AW-1:0] pc;
    logic          irq_ack;
    logic          ien;
    logic [DW-1:0] depth;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_ovf;
    logic          stack_unf;
    logic          z_restore;
    logic          c_restore;
    logic          flag_restore;

    modport master (
        output op6, imm, z, c, irq,
        input  pc, irq_ack, ien, depth, stack_full, stack_empty,
               stack_ovf, stack_unf, z_restore, c_restore, flag_restore
    );

    modport slave (
        input  op6, imm, z, c, irq,
        output pc, irq_ack, ien, depth, stack_full, stack_empty,
               stack_ovf, stack_unf, z_restore, c_restore, flag_restore
    );
endinterface

// File: rtl/trisc_pcu.sv
// T-RISC program-control unit: PC, return stack, conditional branches, one vectored interrupt.
// Define TRISC_PCU_FLAGSAVE_EN to save {z,c} on interrupt entry and restore them on reti.
module trisc_pcu #(
    parameter int            AW        = 12,
    parameter int            DEPTH     = 32,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [AW-1:0] IRQ_VEC   = AW'(1),
    parameter int            DW        = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       reset,
    trisc_pcu_if.slave bus
);
    localparam logic [5:0] OP_JUMP   = 6'b100010;
    localparam logic [5:0] OP_JUMPZ  = 6'b110010;
    localparam logic [5:0] OP_JUMPNZ = 6'b110110;
    localparam logic [5:0] OP_JUMPC  = 6'b111010;
    localparam logic [5:0] OP_JUMPNC = 6'b111110;
    localparam logic [5:0] OP_CALL   = 6'b100000;
    localparam logic [5:0] OP_RET    = 6'b100101;
    localparam logic [5:0] OP_RETI   = 6'b100111;
    localparam logic [5:0] OP_EINT   = 6'b101000;
    localparam logic [5:0] OP_DINT   = 6'b101001;
`ifdef TRISC_PCU_FLAGSAVE_EN
    localparam int SW = AW + 2;
`else
    localparam int SW = AW;
`endif
    localparam int IW = $clog2(DEPTH);

    logic [SW-1:0] stk_q [DEPTH];
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ien_q, ien_d, ovf_q, ovf_d, unf_q, unf_d, ack_q, ack_d;
    logic          full, empty;
    logic [AW-1:0] pc1, npc;
    logic [SW-1:0] top, push_data;
    logic [IW-1:0] rd_idx, wr_idx;
    logic          is_call, is_ret, is_reti, irq_blk, jmp_taken;
    logic          call_ok, pop_ok, irq_take, push;

    assign full   = (depth_q == DW'(DEPTH));
    assign empty  = (depth_q == '0);
    assign pc1    = pc_q + AW'(1);
    assign rd_idx = IW'(depth_q - DW'(1));
    assign wr_idx = IW'(depth_q);
    assign top    = stk_q[rd_idx];

    always_comb begin
        is_call   = (bus.op6 == OP_CALL);
        is_reti   = (bus.op6 == OP_RETI);
        is_ret    = (bus.op6 == OP_RET) || is_reti;
        irq_blk   = is_call || is_ret || (bus.op6 == OP_EINT) || (bus.op6 == OP_DINT);
        jmp_taken = 1'b0;
        unique case (bus.op6)
            OP_JUMP:   jmp_taken = 1'b1;
            OP_JUMPZ:  jmp_taken = bus.z;
            OP_JUMPNZ: jmp_taken = !bus.z;
            OP_JUMPC:  jmp_taken = bus.c;
            OP_JUMPNC: jmp_taken = !bus.c;
            default:   jmp_taken = 1'b0;
        endcase
        call_ok  = is_call && !full;
        pop_ok   = is_ret && !empty;
        // npc is also what an accepted interrupt pushes, so a taken jump resumes at its target
        if (call_ok || jmp_taken) npc = bus.imm;
        else if (pop_ok)          npc = top[AW-1:0];
        else                      npc = pc1;
        irq_take = bus.irq && ien_q && !irq_blk && !full;
        push     = call_ok || irq_take;
`ifdef TRISC_PCU_FLAGSAVE_EN
        push_data = irq_take ? {bus.z, bus.c, npc} : {2'b00, pc1};
`else
        push_data = irq_take ? npc : pc1;
`endif
        pc_d = irq_take ? IRQ_VEC : npc;
        if (push)        depth_d = depth_q + DW'(1);
        else if (pop_ok) depth_d = depth_q - DW'(1);
        else             depth_d = depth_q;
        ien_d = ien_q;
        if (irq_take)                    ien_d = 1'b0;
        else if (bus.op6 == OP_EINT)     ien_d = 1'b1;
        else if (bus.op6 == OP_DINT)     ien_d = 1'b0;
        else if (is_reti && pop_ok)      ien_d = 1'b1;
        ovf_d = ovf_q || (is_call && full) || (bus.irq && ien_q && full);
        unf_d = unf_q || (is_ret && empty);
        ack_d = irq_take;
    end

    // Stack storage has no reset; only depth tracks validity
    always_ff @(negedge clk) begin
        if (push) stk_q[wr_idx] <= push_data;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ien_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ien_q   <= ien_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ack_q   <= ack_d;
        end
    end

`ifdef TRISC_PCU_FLAGSAVE_EN
    logic zr_q, cr_q, fr_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            zr_q <= 1'b0;
            cr_q <= 1'b0;
            fr_q <= 1'b0;
        end else begin
            fr_q <= is_reti && pop_ok;
            if (is_reti && pop_ok) begin
                zr_q <= top[AW+1];
                cr_q <= top[AW];
            end
        end
    end

    assign bus.z_restore    = zr_q;
    assign bus.c_restore    = cr_q;
    assign bus.flag_restore = fr_q;
`else
    assign bus.z_restore    = 1'b0;
    assign bus.c_restore    = 1'b0;
    assign bus.flag_restore = 1'b0;
`endif

    assign bus.pc          = pc_q;
    assign bus.depth       = depth_q;
    assign bus.ien         = ien_q;
    assign bus.irq_ack     = ack_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_trisc_pcu.sv
// Directed-vector bench for trisc_pcu with a 4-entry return stack.
// Expected flag-restore columns follow TRISC_PCU_FLAGSAVE_EN.
module tb_trisc_pcu;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int DW    = 3;
`ifdef TRISC_PCU_FLAGSAVE_EN
    localparam logic FS = 1'b1;
`else
    localparam logic FS = 1'b0;
`endif
    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] JMP  = 6'b100010;
    localparam logic [5:0] JZ   = 6'b110010;
    localparam logic [5:0] JNZ  = 6'b110110;
    localparam logic [5:0] JC   = 6'b111010;
    localparam logic [5:0] JNC  = 6'b111110;
    localparam logic [5:0] CALL = 6'b100000;
    localparam logic [5:0] RET  = 6'b100101;
    localparam logic [5:0] RETI = 6'b100111;
    localparam logic [5:0] EINT = 6'b101000;
    localparam logic [5:0] DINT = 6'b101001;

    typedef struct packed {
        logic [5:0]  op;
        logic [11:0] imm;
        logic        z, c, irq;
        logic [11:0] pc;
        logic [2:0]  d;
        logic        ien, ack, ovf, unf, fr, zr, cr;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t tbl [34];

    trisc_pcu_if #(.AW(AW), .DW(DW)) bus ();

    trisc_pcu #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic [5:0] op, logic [11:0] imm, logic z, logic c, logic irq,
                                logic [11:0] pc, logic [2:0] d, logic ien, logic ack,
                                logic ovf, logic unf, logic fr, logic zr, logic cr);
        vec_t v;
        v = {op, imm, z, c, irq, pc, d, ien, ack, ovf, unf, fr, zr, cr};
        return v;
    endfunction

    task automatic check(input string tag, input logic [11:0] pc, input logic [2:0] d,
                         input logic ien, input logic ack, input logic ovf, input logic unf,
                         input logic fr, input logic zr, input logic cr);
        logic [23:0] act, exp;
        act = {bus.pc, bus.depth, bus.stack_full, bus.stack_empty, bus.ien, bus.irq_ack,
               bus.stack_ovf, bus.stack_unf, bus.flag_restore, bus.z_restore, bus.c_restore};
        exp = {pc, d, (d == 3'd4), (d == 3'd0), ien, ack, ovf, unf, fr, zr, cr};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h depth=%0d flags=%b, want pc=%h depth=%0d flags=%b",
                     tag, act[23:12], act[11:9], act[8:0], exp[23:12], exp[11:9], exp[8:0]);
        end
    endtask

    // Inputs are driven mid-cycle, the DUT updates on the falling edge, outputs are read 2 ns later
    task automatic apply(input vec_t v, input string tag);
        bus.op6 = v.op;
        bus.imm = v.imm;
        bus.z   = v.z;
        bus.c   = v.c;
        bus.irq = v.irq;
        @(negedge clk);
        #2;
        check(tag, v.pc, v.d, v.ien, v.ack, v.ovf, v.unf, v.fr, v.zr, v.cr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            op    imm    z  c  irq  pc     d  ien ack ovf unf fr  zr  cr
        tbl[0]  = mk(NOP,  12'h000, 0, 0, 0, 12'h001, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(NOP,  12'h000, 0, 0, 0, 12'h002, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(NOP,  12'h000, 0, 0, 0, 12'h003, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(JMP,  12'h005, 0, 0, 0, 12'h005, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(CALL, 12'h100, 0, 0, 0, 12'h100, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(RET,  12'h000, 0, 0, 0, 12'h006, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(JZ,   12'h040, 0, 0, 0, 12'h007, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(JC,   12'h040, 0, 1, 0, 12'h040, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(JNZ,  12'h050, 0, 0, 0, 12'h050, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(JNC,  12'h060, 0, 1, 0, 12'h051, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(JZ,   12'h070, 1, 0, 0, 12'h070, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(JNC,  12'h080, 0, 0, 0, 12'h080, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(CALL, 12'h200, 0, 0, 0, 12'h200, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(CALL, 12'h300, 0, 0, 0, 12'h300, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(CALL, 12'h400, 0, 0, 0, 12'h400, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(CALL, 12'h500, 0, 0, 0, 12'h500, 4, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(CALL, 12'h600, 0, 0, 0, 12'h501, 4, 0, 0, 1, 0, 0, 0, 0);
        tbl[17] = mk(RET,  12'h000, 0, 0, 0, 12'h401, 3, 0, 0, 1, 0, 0, 0, 0);
        tbl[18] = mk(RET,  12'h000, 0, 0, 0, 12'h301, 2, 0, 0, 1, 0, 0, 0, 0);
        tbl[19] = mk(RET,  12'h000, 0, 0, 0, 12'h201, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[20] = mk(RET,  12'h000, 0, 0, 0, 12'h081, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[21] = mk(RET,  12'h000, 0, 0, 0, 12'h082, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[22] = mk(JMP,  12'h00F, 0, 0, 0, 12'h00F, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[23] = mk(EINT, 12'h000, 0, 0, 1, 12'h010, 0, 1, 0, 1, 1, 0, 0, 0);
        tbl[24] = mk(NOP,  12'h000, 1, 0, 1, 12'h001, 1, 0, 1, 1, 1, 0, 0, 0);
        tbl[25] = mk(NOP,  12'h000, 0, 0, 1, 12'h002, 1, 0, 0, 1, 1, 0, 0, 0);
        tbl[26] = mk(RETI, 12'h000, 0, 0, 0, 12'h011, 0, 1, 0, 1, 1, FS, FS, 0);
        tbl[27] = mk(NOP,  12'h000, 0, 0, 0, 12'h012, 0, 1, 0, 1, 1, 0, FS, 0);
        tbl[28] = mk(CALL, 12'h020, 0, 0, 1, 12'h020, 1, 1, 0, 1, 1, 0, FS, 0);
        tbl[29] = mk(RET,  12'h000, 0, 0, 0, 12'h013, 0, 1, 0, 1, 1, 0, FS, 0);
        tbl[30] = mk(JMP,  12'h090, 0, 1, 1, 12'h001, 1, 0, 1, 1, 1, 0, FS, 0);
        tbl[31] = mk(RETI, 12'h000, 0, 0, 0, 12'h090, 0, 1, 0, 1, 1, FS, 0, FS);
        tbl[32] = mk(DINT, 12'h000, 0, 0, 0, 12'h091, 0, 0, 0, 1, 1, 0, 0, FS);
        tbl[33] = mk(NOP,  12'h000, 0, 0, 1, 12'h092, 0, 0, 0, 1, 1, 0, 0, FS);

        reset   = 1'b0;
        bus.op6 = NOP;
        bus.imm = '0;
        bus.z   = 1'b0;
        bus.c   = 1'b0;
        bus.irq = 1'b0;
        #2;
        check("reset_state", 12'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Three-deep call chain, then an asynchronous reset between clock edges
        apply(mk(EINT, 12'h000, 0, 0, 0, 12'h093, 0, 1, 0, 1, 1, 0, 0, FS), "chain_eint");
        apply(mk(CALL, 12'h010, 0, 0, 0, 12'h010, 1, 1, 0, 1, 1, 0, 0, FS), "chain_call1");
        apply(mk(CALL, 12'h020, 0, 0, 0, 12'h020, 2, 1, 0, 1, 1, 0, 0, FS), "chain_call2");
        apply(mk(CALL, 12'h030, 0, 0, 0, 12'h030, 3, 1, 0, 1, 1, 0, 0, FS), "chain_call3");
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_mid_chain", 12'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.op6 = NOP;
        #1;
        reset = 1'b1;

        // Interrupt while the stack is full: refused, overflow flagged, taken once room appears
        apply(mk(EINT, 12'h000, 0, 0, 0, 12'h001, 0, 1, 0, 0, 0, 0, 0, 0), "full_eint");
        apply(mk(CALL, 12'h040, 0, 0, 0, 12'h040, 1, 1, 0, 0, 0, 0, 0, 0), "full_call1");
        apply(mk(CALL, 12'h041, 0, 0, 0, 12'h041, 2, 1, 0, 0, 0, 0, 0, 0), "full_call2");
        apply(mk(CALL, 12'h042, 0, 0, 0, 12'h042, 3, 1, 0, 0, 0, 0, 0, 0), "full_call3");
        apply(mk(CALL, 12'h043, 0, 0, 0, 12'h043, 4, 1, 0, 0, 0, 0, 0, 0), "full_call4");
        apply(mk(NOP,  12'h000, 0, 0, 1, 12'h044, 4, 1, 0, 1, 0, 0, 0, 0), "full_irq_refused");
        apply(mk(NOP,  12'h000, 0, 0, 0, 12'h045, 4, 1, 0, 1, 0, 0, 0, 0), "full_ovf_sticky");
        apply(mk(RET,  12'h000, 0, 0, 1, 12'h043, 3, 1, 0, 1, 0, 0, 0, 0), "full_ret_blocks_irq");
        apply(mk(NOP,  12'h000, 0, 0, 1, 12'h001, 4, 0, 1, 1, 0, 0, 0, 0), "full_irq_taken");
        apply(mk(RETI, 12'h000, 0, 0, 0, 12'h044, 3, 1, 0, 1, 0, FS, 0, 0), "full_reti");
        apply(mk(RET,  12'h000, 0, 0, 0, 12'h042, 2, 1, 0, 1, 0, 0, 0, 0), "full_ret_no_strobe");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
